// File: rtl/clock_ratio_detector.sv
// clock_ratio_detector
// Measures period and high time of a slow clock-like input in reference
// clk cycles, declares lock once the period repeats, and flags a stalled input.
module clock_ratio_detector #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             locked,
  output logic             lock_lost,
  output logic             stalled,
  output logic             is_pow2
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_MEASURE,
    S_LOCKED
  } state_t;

  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [4:0]       LOCK_N = 5'(LOCK_COUNT);

  state_t                 state;
  state_t                 state_n;
  logic [3:0]             match_cnt;
  logic [3:0]             match_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  logic                   s_d;
  logic                   rise;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       hcnt;
  logic [CNT_W:0]         meas_ext;
  logic [CNT_W-1:0]       meas_period;
  logic                   same;
  logic                   tmo_hit;
  logic [4:0]             match_inc;
  logic                   take;
  logic                   stall;
  logic                   lost;

  // Synchroniser chain for the asynchronous input plus one delay flop for edge detect
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign rise   = s_sync & ~s_d;

  // Interval counter (saturates at TIMEOUT) and high-time counter (saturates at all-ones)
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (rise) begin
      cnt  <= '0;
      hcnt <= CNT_W'(1);
    end else begin
      if (cnt != TMO)
        cnt <= cnt + 1'b1;
      if (s_sync && (hcnt != '1))
        hcnt <= hcnt + 1'b1;
    end
  end

  // Measured period with saturation at all-ones, compared against the previous one
  always_comb begin
    meas_ext    = {1'b0, cnt} + 1'b1;
    meas_period = meas_ext[CNT_W] ? '1 : meas_ext[CNT_W-1:0];
    same        = (meas_period == period);
    tmo_hit     = !rise && (cnt >= TMO_M1);
    match_inc   = {1'b0, match_cnt} + 5'd1;
  end

  // FSM state and match counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      match_cnt <= '0;
    end else begin
      state     <= state_n;
      match_cnt <= match_n;
    end
  end

  // Next-state logic; a rise always wins over a coincident timeout
  always_comb begin
    state_n = state;
    match_n = match_cnt;
    case (state)
      S_IDLE: begin
        if (rise)
          state_n = S_ARMED;
      end
      S_ARMED: begin
        if (rise) begin
          state_n = S_MEASURE;
          match_n = '0;
        end else if (tmo_hit) begin
          state_n = S_IDLE;
          match_n = '0;
        end
      end
      S_MEASURE: begin
        if (rise) begin
          if (same) begin
            match_n = match_inc[3:0];
            if (match_inc >= LOCK_N)
              state_n = S_LOCKED;
          end else begin
            match_n = '0;
          end
        end else if (tmo_hit) begin
          state_n = S_IDLE;
          match_n = '0;
        end
      end
      S_LOCKED: begin
        if (rise) begin
          if (!same) begin
            state_n = S_MEASURE;
            match_n = '0;
          end
        end else if (tmo_hit) begin
          state_n = S_IDLE;
          match_n = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
        match_n = '0;
      end
    endcase
  end

  // Output event decode from current state and input events
  always_comb begin
    take  = rise && (state != S_IDLE);
    stall = tmo_hit && (state != S_IDLE);
    lost  = rise && (state == S_LOCKED) && !same;
  end

  // Registered measurement outputs and event pulses; period/high_time hold on timeout
  always_ff @(posedge clk) begin
    if (!rst) begin
      meas_valid <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      lock_lost  <= 1'b0;
      stalled    <= 1'b0;
    end else begin
      meas_valid <= take;
      lock_lost  <= lost;
      stalled    <= stall;
      if (take) begin
        period    <= meas_period;
        high_time <= hcnt;
      end
    end
  end

  // Lock flag and power-of-two classification of the locked period
  always_comb begin
    locked  = (state == S_LOCKED);
    is_pow2 = locked && (period != '0) && ((period & (period - 1'b1)) == '0);
  end

endmodule

// File: tb/tb_clock_ratio_detector.sv
// Self-checking bench for clock_ratio_detector: directed waveforms plus random
// high/low patterns, checked every cycle against an interval-based reference model.
module tb_clock_ratio_detector;

  localparam int W    = 8;
  localparam int S    = 2;
  localparam int LC   = 3;
  localparam int TO   = 255;
  localparam int MAXV = (1 << W) - 1;

  logic         clk;
  logic         rst;
  logic         sig_in;
  logic         meas_valid;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         locked;
  logic         lock_lost;
  logic         stalled;
  logic         is_pow2;

  clock_ratio_detector #(
    .CNT_W      (W),
    .SYNC_STAGES(S),
    .LOCK_COUNT (LC),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .meas_valid(meas_valid),
    .period    (period),
    .high_time (high_time),
    .locked    (locked),
    .lock_lost (lock_lost),
    .stalled   (stalled),
    .is_pow2   (is_pow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state: delayed samples, time of last detected rise,
  // high cycles since it, and the run of consecutive equal periods
  bit dl[0:S];
  int ecnt;
  int rise_e;
  int hi;
  int run;
  int nmeas;
  bit armed;
  bit m_mv, m_lost, m_stall, m_locked;
  int m_period, m_high;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, ecnt, obs, exp);
    end
  endtask

  task automatic model_edge(input bit v, input bit r);
    bit sv, pv, rise, was;
    int p, h;
    m_mv = 0; m_lost = 0; m_stall = 0;
    if (!r) begin
      for (int i = 0; i <= S; i++) dl[i] = 0;
      armed = 0; run = 0; nmeas = 0; hi = 0;
      m_locked = 0; m_period = 0; m_high = 0;
      ecnt++;
      return;
    end
    sv = dl[S-1];
    pv = dl[S];
    rise = sv && !pv;
    if (rise) begin
      if (armed) begin
        p = ecnt - rise_e;
        if (p > MAXV) p = MAXV;
        h = (hi > MAXV) ? MAXV : hi;
        if (nmeas > 0 && p == m_period) run++;
        else run = 1;
        nmeas++;
        was = m_locked;
        m_locked = (run >= LC + 1);
        m_lost = was && !m_locked;
        m_mv = 1;
        m_period = p;
        m_high = h;
      end
      armed = 1;
      rise_e = ecnt;
      hi = 1;
    end else begin
      if (armed && (ecnt - rise_e) == TO) begin
        m_stall = 1;
        armed = 0;
        m_locked = 0;
        nmeas = 0;
        run = 0;
      end
      hi += int'(sv);
    end
    for (int i = S; i >= 1; i--) dl[i] = dl[i-1];
    dl[0] = v;
    ecnt++;
  endtask

  task automatic check_all();
    bit pw;
    pw = 0;
    for (int k = 0; k < W; k++)
      if (m_period == (1 << k)) pw = 1;
    chk("meas_valid", 32'(meas_valid), 32'(m_mv));
    chk("period",     32'(period),     32'(m_period));
    chk("high_time",  32'(high_time),  32'(m_high));
    chk("locked",     32'(locked),     32'(m_locked));
    chk("lock_lost",  32'(lock_lost),  32'(m_lost));
    chk("stalled",    32'(stalled),    32'(m_stall));
    chk("is_pow2",    32'(is_pow2),    32'(m_locked && pw));
  endtask

  task automatic tick(input bit v, input bit r);
    sig_in = v;
    rst = r;
    @(posedge clk);
    model_edge(v, r);
    #1;
    check_all();
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (h) tick(1'b1, 1'b1);
      repeat (l) tick(1'b0, 1'b1);
    end
  endtask

  task automatic hold(input bit v, input int n);
    repeat (n) tick(v, 1'b1);
  endtask

  initial begin
    sig_in = 1'b0;
    rst = 1'b0;
    ecnt = 0;
    rise_e = 0;
    for (int i = 0; i <= S; i++) dl[i] = 0;
    // reset state
    repeat (3) tick(1'b0, 1'b0);
    chk("reset_period", 32'(period), 32'd0);
    chk("reset_locked", 32'(locked), 32'd0);

    // divide-by-2
    wave(1, 1, 12);
    chk("div2_locked", 32'(locked), 32'd1);
    chk("div2_pow2",   32'(is_pow2), 32'd1);
    chk("div2_period", 32'(period), 32'd2);

    // divide-by-16, long locked run
    wave(8, 8, 25);
    chk("div16_period", 32'(period), 32'd16);
    chk("div16_high",   32'(high_time), 32'd8);
    chk("div16_locked", 32'(locked), 32'd1);

    // divide-by-4 then divide-by-8: lock lost then regained
    wave(2, 2, 8);
    wave(4, 4, 6);
    chk("div8_relock", 32'(locked), 32'd1);

    // locked on divide-by-4 then input stuck low: stall, then re-arm
    wave(2, 2, 8);
    hold(1'b0, 300);
    chk("stall_unlocked", 32'(locked), 32'd0);
    wave(2, 2, 3);

    // non-power-of-two waveforms
    wave(3, 5, 8);
    chk("np2_high", 32'(high_time), 32'd3);
    wave(3, 3, 8);
    chk("np2_period", 32'(period), 32'd6);
    chk("np2_pow2",   32'(is_pow2), 32'd0);

    // reset for one cycle in the middle of measuring
    wave(2, 2, 3);
    tick(1'b1, 1'b0);
    chk("midrst_period", 32'(period), 32'd0);
    wave(2, 2, 6);

    // timeout boundary: rise exactly at TIMEOUT measures, one later stalls
    hold(1'b0, 10);
    wave(1, 1, 2);
    wave(1, TO - 1, 2);
    hold(1'b0, 20);
    wave(1, 1, 2);
    wave(1, TO, 2);
    hold(1'b0, 10);

    // stuck high
    wave(2, 2, 6);
    hold(1'b1, 280);

    // randomized patterns with repetition so locks occur, plus occasional gaps/resets
    for (int it = 0; it < 60; it++) begin
      int h, l, n, sel;
      h = $urandom_range(1, 12);
      l = $urandom_range(1, 12);
      n = $urandom_range(1, 7);
      wave(h, l, n);
      sel = $urandom_range(0, 15);
      if (sel == 0) hold(1'b0, $urandom_range(TO - 3, TO + 10));
      else if (sel == 1) tick(1'(($urandom_range(0, 1))), 1'b0);
      else if (sel == 2) hold(1'b1, $urandom_range(1, 30));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_ratio_detector.md
Name: clock_ratio_detector

Overview:
- Measures the period and high time of a slow clock-like input, for example a divide-by-2/4/8/16 tap from our clock divider, in cycles of the reference clk.
- Reports a lock once the period has been stable for several consecutive cycles of the input, and detects a stalled input.
- Sits on the receive side of the divider outputs as a self-check / frequency-ratio monitor.

Parameters:
- CNT_W, 8, width of period/high-time counters and outputs.
- SYNC_STAGES, 2, flops in sig_in synchroniser (>=2).
- LOCK_COUNT, 3, consecutive matching measurements required for lock (1..15).
- TIMEOUT, 255, clk cycles without a rising edge before the input is declared stalled (2..2^CNT_W-1).

Ports:
- clk  input  1  reference clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- sig_in  input  1  monitored signal; treated as asynchronous.
- meas_valid  output  1  one-cycle pulse when period/high_time updated.
- period  output  CNT_W  last measured rising-to-rising interval in clk cycles.
- high_time  output  CNT_W  clk cycles the synchronised input was high within that interval.
- locked  output  1  period stable for LOCK_COUNT consecutive matches.
- lock_lost  output  1  one-cycle pulse when leaving LOCKED.
- stalled  output  1  one-cycle pulse on timeout.
- is_pow2  output  1  locked period is a power of two (valid only while locked, else 0).

Behaviour:
- Reset (rst==0 at a clk edge): sync chain, delayed copy, counters, match_cnt cleared; all outputs 0; state IDLE.
- Synchroniser: SYNC_STAGES flops, then one delay flop s_d.
  - rise = s_sync & ~s_d.
  - If sig_in is first sampled high at edge k, registered outputs react at edge k+SYNC_STAGES.
- cnt:
  - Cleared on rise; otherwise increments.
  - Saturates at TIMEOUT, never wraps.
- hcnt:
  - On rise: loaded with 1.
  - Otherwise increments while s_sync==1; holds while low.
  - Saturates at 2^CNT_W-1.
- Measurement, on rise in any state other than IDLE:
  - period <= cnt+1; high_time <= hcnt.
  - meas_valid pulses 1 cycle.
  - Example: a divide-by-2 input gives period=2, high_time=1.
- FSM states:
  - IDLE: no reference edge yet. On rise -> ARMED. No measurement.
  - ARMED: on rise -> MEASURE; first measurement taken; match_cnt <= 0.
  - MEASURE: on rise, if new period == previous period then match_cnt+1, else match_cnt <= 0. When match_cnt reaches LOCK_COUNT -> LOCKED; locked asserts in the same cycle as that meas_valid.
  - LOCKED: on rise with equal period, stay. On unequal period -> MEASURE, locked <= 0, lock_lost pulse, match_cnt <= 0, new period reported.
- Lock timing: lock requires LOCK_COUNT+1 measurements, i.e. LOCK_COUNT+2 rising edges after IDLE.
- Timeout:
  - In any non-IDLE state, cnt reaching TIMEOUT without rise -> IDLE, stalled pulse, locked <= 0.
  - No lock_lost pulse on timeout.
  - period and high_time hold their last values.
- Simultaneous events: rise in the same cycle cnt would reach TIMEOUT takes priority; the measurement is taken and no stall occurs.
- Measured-period saturation: if cnt+1 would exceed 2^CNT_W-1, period saturates at all-ones.
- is_pow2 = locked & (period!=0) & ((period & (period-1))==0).
- Mid-operation reset: reset dominates everything. After release, the first rise only arms; no stale measurement is reported.
- sig_in stuck high or stuck low: no rises, so timeout as above.

Test Plan:
- Divide-by-2 input (toggle every clk): meas_valid every 2 cycles with period=2, high_time=1; locked=1 on the 5th rise; is_pow2=1.
- Divide-by-16 input (8 high/8 low): period=16, high_time=8, locked after 5 rises; stays locked for 20 periods with no lock_lost.
- Locked on divide-by-4, then switch to divide-by-8: one meas_valid with period=8 and lock_lost=1; locked=0, then re-lock after 3 further matching periods of 8.
- Locked on divide-by-4, then hold sig_in low: stalled pulses TIMEOUT=255 cycles after the last detected rise; locked=0; next two rises arm then measure, with no spurious period.
- Non-power-of-2 waveform, 3 high/5 low: period=8, high_time=3. Then 3 high/3 low: period=6, is_pow2=0 once locked.
- Assert rst=0 for 1 cycle mid-MEASURE: all outputs 0 next cycle; first rise after release yields no meas_valid; second rise yields a correct period.
